// File: rtl/mc_main_fsm_if.sv
// Bus between the multicycle controller and the datapath: instruction fields
// and memory handshake in, datapath control strobes out.
interface mc_main_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       MemReady;

  logic       IRWrite;
  logic       NextPC;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       PCS;
  logic       InstrDone;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [1:0] FlagW;
  logic [3:0] State;

  modport master (
    output Op, Funct, Rd, MemReady,
    input  IRWrite, NextPC, AdrSrc, ALUSrcA, RegW, MemW, Branch, PCS,
           InstrDone, ResultSrc, ALUSrcB, ALUControl, FlagW, State
  );

  modport slave (
    input  Op, Funct, Rd, MemReady,
    output IRWrite, NextPC, AdrSrc, ALUSrcA, RegW, MemW, Branch, PCS,
           InstrDone, ResultSrc, ALUSrcB, ALUControl, FlagW, State
  );
endinterface

// File: rtl/mc_main_fsm.sv
// Main control FSM of a multicycle ARM-subset processor: Moore state register
// with combinational control decode, including the ALU decoder.
module mc_main_fsm #(
  parameter bit USE_READY = 1'b1
) (
  input logic          clk,
  input logic          reset,
  mc_main_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic       ready;
  logic [3:0] cmd;

  logic       irwrite, nextpc, adrsrc, alusrca, regw, memw, branch, pcs, done;
  logic [1:0] resultsrc, alusrcb, aluctl, flagw;
  logic       alu_dec;

  assign ready = USE_READY ? bus.MemReady : 1'b1;
  assign cmd   = bus.Funct[4:1];

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: state_d = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = ready ? MEMWB : MEMRD;
      MEMWR:  state_d = ready ? FETCH : MEMWR;
      EXECR:  state_d = ALUWB;
      EXECI:  state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    irwrite   = 1'b0;
    nextpc    = 1'b0;
    adrsrc    = 1'b0;
    alusrca   = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    branch    = 1'b0;
    done      = 1'b0;
    resultsrc = 2'b00;
    alusrcb   = 2'b00;
    aluctl    = 2'b00;
    flagw     = 2'b00;
    alu_dec   = 1'b0;

    case (state_q)
      FETCH: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = ready;
        nextpc    = ready;
      end
      DECODE: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        done      = (bus.Op == 2'b11);
      end
      MEMADR: alusrcb = 2'b01;
      MEMRD:  adrsrc = 1'b1;
      MEMWB: begin
        resultsrc = 2'b01;
        regw      = 1'b1;
        done      = 1'b1;
      end
      MEMWR: begin
        adrsrc = 1'b1;
        memw   = 1'b1;
        done   = ready;
      end
      EXECR: alu_dec = 1'b1;
      EXECI: begin
        alusrcb = 2'b01;
        alu_dec = 1'b1;
      end
      ALUWB: begin
        regw = 1'b1;
        done = 1'b1;
      end
      BRANCH: begin
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        branch    = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase

    // Unlisted commands fall back to ADD; only ADD/SUB update C and V.
    if (alu_dec) begin
      case (cmd)
        4'b0100: aluctl = 2'b00;
        4'b0010: aluctl = 2'b01;
        4'b0000: aluctl = 2'b10;
        4'b1100: aluctl = 2'b11;
        default: aluctl = 2'b00;
      endcase
      flagw = {bus.Funct[0], bus.Funct[0] & ((cmd == 4'b0100) | (cmd == 4'b0010))};
    end

    // While in reset, strobes are quiet and selects look like FETCH.
    if (!reset) begin
      irwrite   = 1'b0;
      nextpc    = 1'b0;
      adrsrc    = 1'b0;
      regw      = 1'b0;
      memw      = 1'b0;
      branch    = 1'b0;
      done      = 1'b0;
      flagw     = 2'b00;
      aluctl    = 2'b00;
      alusrca   = 1'b1;
      alusrcb   = 2'b10;
      resultsrc = 2'b10;
    end

    pcs = branch | (regw & (bus.Rd == 4'hF));
  end

  assign bus.IRWrite    = irwrite;
  assign bus.NextPC     = nextpc;
  assign bus.AdrSrc     = adrsrc;
  assign bus.ALUSrcA    = alusrca;
  assign bus.RegW       = regw;
  assign bus.MemW       = memw;
  assign bus.Branch     = branch;
  assign bus.PCS        = pcs;
  assign bus.InstrDone  = done;
  assign bus.ResultSrc  = resultsrc;
  assign bus.ALUSrcB    = alusrcb;
  assign bus.ALUControl = aluctl;
  assign bus.FlagW      = flagw;
  assign bus.State      = state_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Bench for mc_main_fsm: directed instructions then randomized traffic,
// checked each cycle against an instruction-level reference model.
module tb_mc_main_fsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_main_fsm_if bus ();
  mc_main_fsm #(.USE_READY(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  int         m_state;
  int         m_path[$];
  logic [1:0] t_op;
  logic [5:0] t_funct;
  logic [3:0] t_rd;
  logic       t_ready;
  int         stall_cnt;
  bit         rand_ready;
  int         trace[$];
  int         done_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected control word for a state number, read straight off the output table.
  function automatic logic [16:0] model_outs(int st, bit rdy, bit rst_n,
                                             logic [5:0] f, logic [3:0] rd, bit done);
    logic irw, npc, adr, sa, rw, mw, br, pcs;
    logic [1:0] rs, sb, ac, fw;
    int cmd;
    irw = 0; npc = 0; adr = 0; sa = 0; rw = 0; mw = 0; br = 0;
    rs = 0; sb = 0; ac = 0; fw = 0;
    cmd = int'(f[4:1]);
    case (st)
      0: begin sa = 1; sb = 2; rs = 2; irw = rdy; npc = rdy; end
      1: begin sa = 1; sb = 2; rs = 2; end
      2: sb = 1;
      3: adr = 1;
      4: begin rs = 1; rw = 1; end
      5: begin adr = 1; mw = 1; end
      6, 7: begin
        sb = (st == 7) ? 2'd1 : 2'd0;
        if (cmd == 4) ac = 0;
        else if (cmd == 2) ac = 1;
        else if (cmd == 0) ac = 2;
        else if (cmd == 12) ac = 3;
        else ac = 0;
        fw[1] = f[0];
        fw[0] = f[0] && (cmd == 4 || cmd == 2);
      end
      8: rw = 1;
      9: begin sb = 1; rs = 2; br = 1; end
      default: ;
    endcase
    if (!rst_n) begin
      irw = 0; npc = 0; adr = 0; rw = 0; mw = 0; br = 0; fw = 0; ac = 0;
      sa = 1; sb = 2; rs = 2;
    end
    pcs = br | (rw & (rd == 4'hF));
    return {irw, npc, adr, sa, rw, mw, br, pcs, done, rs, sb, ac, fw};
  endfunction

  // Instruction-level model: DECODE plans the remaining steps of the instruction;
  // FETCH, MEMRD and MEMWR hold until memory is ready.
  task automatic model_step();
    bit waits;
    if (!reset) begin
      m_state = 0;
      m_path.delete();
    end else begin
      waits = (m_state == 0 || m_state == 3 || m_state == 5);
      if (waits && !t_ready) begin
      end else if (m_state == 0) begin
        m_state = 1;
      end else begin
        if (m_state == 1) begin
          m_path.delete();
          case (t_op)
            2'b00: begin m_path.push_back(t_funct[5] ? 7 : 6); m_path.push_back(8); end
            2'b01: begin
              m_path.push_back(2);
              if (t_funct[0]) begin m_path.push_back(3); m_path.push_back(4); end
              else m_path.push_back(5);
            end
            2'b10: m_path.push_back(9);
            default: ;
          endcase
        end
        m_state = (m_path.size() > 0) ? m_path.pop_front() : 0;
      end
    end
  endtask

  task automatic run_cycle();
    bit waits, adv, exp_done;
    logic [16:0] obs;
    if (rand_ready) t_ready = ($urandom_range(0, 3) != 0);
    else if ((m_state == 3 || m_state == 5) && stall_cnt > 0) begin
      t_ready = 1'b0;
      stall_cnt--;
    end else t_ready = 1'b1;
    bus.Op = t_op; bus.Funct = t_funct; bus.Rd = t_rd; bus.MemReady = t_ready;
    @(negedge clk);
    waits = (m_state == 0 || m_state == 3 || m_state == 5);
    adv = !waits || t_ready;
    if (m_state == 1) exp_done = (t_op == 2'b11);
    else exp_done = (m_state > 1) && adv && (m_path.size() == 0);
    exp_done = exp_done && reset;
    if (m_state >= 0) chk("state", 32'(bus.State), 32'(m_state));
    obs = {bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA, bus.RegW, bus.MemW,
           bus.Branch, bus.PCS, bus.InstrDone, bus.ResultSrc, bus.ALUSrcB,
           bus.ALUControl, bus.FlagW};
    chk($sformatf("outs_s%0d", m_state), 32'(obs),
        32'(model_outs(m_state, t_ready, reset, t_funct, t_rd, exp_done)));
    trace.push_back(int'(bus.State));
    if (bus.InstrDone === 1'b1) done_cnt++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_instr(input logic [1:0] op, input logic [5:0] f,
                          input logic [3:0] rd, input int stall);
    int n;
    t_op = op; t_funct = f; t_rd = rd; stall_cnt = stall;
    trace.delete();
    n = 0;
    do begin
      run_cycle();
      n++;
    end while (m_state != 0 && n < 50);
    chk("instr_bound", 32'(n < 50), 32'd1);
  endtask

  task automatic chk_trace(input string tag, input int e[$]);
    chk({tag, "_len"}, 32'(trace.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < trace.size(); i++)
      chk(tag, 32'(trace[i]), 32'(e[i]));
  endtask

  initial begin
    int n;
    int cmdv;
    rand_ready = 0; stall_cnt = 0; done_cnt = 0;
    t_op = 0; t_funct = 0; t_rd = 0; t_ready = 1;
    m_state = -1;
    reset = 1'b0;
    run_cycle();
    run_cycle();
    reset = 1'b1;
    chk("rst_state", 32'(bus.State), 32'd0);

    do_instr(2'b00, 6'b001001, 4'd3, 0);
    chk_trace("add_trace", '{0, 1, 6, 8});
    chk("add_done", 32'(done_cnt), 32'd1);
    do_instr(2'b01, 6'b000001, 4'd2, 2);
    chk_trace("ldr_trace", '{0, 1, 2, 3, 3, 3, 4});
    do_instr(2'b01, 6'b000000, 4'd2, 3);
    chk_trace("str_trace", '{0, 1, 2, 5, 5, 5, 5});
    do_instr(2'b00, 6'b111000, 4'd15, 0);
    chk_trace("orr_trace", '{0, 1, 7, 8});
    do_instr(2'b10, 6'b000000, 4'd0, 0);
    chk_trace("b_trace", '{0, 1, 9});
    do_instr(2'b11, 6'b000000, 4'd0, 0);
    chk_trace("ill_trace", '{0, 1});
    chk("dir_done", 32'(done_cnt), 32'd6);

    // Reset while stalled in MEMWR.
    t_op = 2'b01; t_funct = 6'b000000; t_rd = 4'd1; stall_cnt = 100;
    n = 0;
    while (m_state != 5 && n < 10) begin run_cycle(); n++; end
    chk("reach_memwr", 32'(m_state), 32'd5);
    run_cycle();
    reset = 1'b0;
    run_cycle();
    reset = 1'b1;
    stall_cnt = 0;
    chk("rst_mid_state", 32'(bus.State), 32'd0);
    chk("rst_mid_memw", 32'(bus.MemW), 32'd0);

    rand_ready = 1;
    for (int i = 0; i < 3000; i++) begin
      if (m_state == 0) begin
        t_op = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 4))
          0: cmdv = 4;
          1: cmdv = 2;
          2: cmdv = 0;
          3: cmdv = 12;
          default: cmdv = $urandom_range(0, 15);
        endcase
        t_funct = {1'($urandom_range(0, 1)), 4'(cmdv), 1'($urandom_range(0, 1))};
        t_rd = 4'($urandom_range(0, 15));
      end
      reset = ($urandom_range(0, 39) != 0);
      run_cycle();
    end
    reset = 1'b1;
    run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
